// File: rtl/cim_pkg.sv
// Shared definitions for the compute-in-memory add path: array geometry
// defaults, the busy FSM state type, and the wordline one-hot check.
package cim_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 8;
    localparam int WL_MAX   = 64;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // Legal wordline: no bit set, or exactly one bit set.
    function automatic logic is_onehot_or_zero(input logic [WL_MAX-1:0] v);
        logic [WL_MAX-1:0] one;
        one = {{(WL_MAX-1){1'b0}}, 1'b1};
        return (v & (v - one)) == '0;
    endfunction

endpackage

// File: rtl/cim_col_fa.sv
// One column of the add array: full adder over the two read bits and
// the column carry latch, which clears or updates on the clock edge.
module cim_col_fa (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic clr,
    input  logic cen,
    output logic sum,
    output logic carry
);

    logic carry_q;
    logic carry_d;
    logic cnext;

    always_comb begin
        sum   = a ^ b ^ carry_q;
        cnext = (a & b) | (a & carry_q) | (b & carry_q);
        carry_d = carry_q;
        if (clr) begin
            carry_d = 1'b0;
        end else if (cen) begin
            carry_d = cnext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry = carry_q;

endmodule

// File: rtl/cim_add_array.sv
// Bit-serial add array: transposed bit-plane storage, wordline decode,
// per-column full adders, busy FSM and a host load/read port.
module cim_add_array
    import cim_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    localparam int AW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] RWLv1,
    input  logic [ROWS-1:0] RWLv2,
    input  logic [ROWS-1:0] WWLp,
    input  logic            C_EN,
    input  logic            CLR,
    input  logic            DONE,
    input  logic            host_we,
    input  logic [AW-1:0]   host_row,
    input  logic [COLS-1:0] host_wdata,
    output logic [COLS-1:0] host_rdata,
    output logic [COLS-1:0] carry,
    output logic            busy,
    output logic            result_valid,
    output logic            wl_err,
    output logic            host_err
);

    logic [COLS-1:0] array_q [ROWS];
    logic [COLS-1:0] array_d [ROWS];
    logic [COLS-1:0] host_rdata_q;
    logic [COLS-1:0] host_rdata_d;
    logic [COLS-1:0] op_a;
    logic [COLS-1:0] op_b;
    logic [COLS-1:0] sum;
    state_e          state_q;
    state_e          state_d;
    logic            result_valid_q;
    logic            result_valid_d;
    logic            wl_err_q;
    logic            wl_err_d;
    logic            host_err_q;
    logic            host_err_d;
    logic            wl_bad;
    logic            wl_ok;
    logic            seq_wr;
    logic            host_ok;
    logic            wl_active;
    logic            clr_eff;
    logic            cen_eff;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (RWLv1[r]) op_a = op_a | array_q[r];
            if (RWLv2[r]) op_b = op_b | array_q[r];
        end
    end

    always_comb begin
        wl_bad = !is_onehot_or_zero(WL_MAX'(RWLv1))
              || !is_onehot_or_zero(WL_MAX'(RWLv2))
              || !is_onehot_or_zero(WL_MAX'(WWLp));
        wl_ok     = !wl_bad;
        wl_active = (RWLv1 != '0) || (RWLv2 != '0) || (WWLp != '0);
        seq_wr    = wl_ok && (WWLp != '0);
        host_ok   = host_we && (state_q == IDLE) && (WWLp == '0);
        clr_eff   = CLR && wl_ok;
        cen_eff   = C_EN && wl_ok;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        cim_col_fa u_fa (
            .clk   (clk),
            .rst_n (rst_n),
            .a     (op_a[c]),
            .b     (op_b[c]),
            .clr   (clr_eff),
            .cen   (cen_eff),
            .sum   (sum[c]),
            .carry (carry[c])
        );
    end

    // Sequencer write is applied last so it wins any overlap with the host.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            array_d[r] = array_q[r];
        end
        if (host_ok) begin
            array_d[host_row] = host_wdata;
        end
        if (seq_wr) begin
            for (int r = 0; r < ROWS; r++) begin
                if (WWLp[r]) array_d[r] = sum;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        result_valid_d = DONE;
        wl_err_d       = wl_err_q | wl_bad;
        host_err_d     = host_we && !host_ok;
        host_rdata_d   = array_q[host_row];
        unique case (state_q)
            IDLE: begin
                if (!DONE && (wl_active || C_EN)) state_d = RUN;
            end
            RUN: begin
                if (DONE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                array_q[r] <= '0;
            end
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            wl_err_q       <= 1'b0;
            host_err_q     <= 1'b0;
            host_rdata_q   <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                array_q[r] <= array_d[r];
            end
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            wl_err_q       <= wl_err_d;
            host_err_q     <= host_err_d;
            host_rdata_q   <= host_rdata_d;
        end
    end

    assign host_rdata   = host_rdata_q;
    assign busy         = (state_q == RUN);
    assign result_valid = result_valid_q;
    assign wl_err       = wl_err_q;
    assign host_err     = host_err_q;

endmodule

// File: tb/tb_cim_add_array.sv
// Directed bench for cim_add_array: host load, bit-plane adds, error
// flags, busy/DONE handshake and reset behaviour.
module tb_cim_add_array;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ROWS-1:0] RWLv1;
    logic [ROWS-1:0] RWLv2;
    logic [ROWS-1:0] WWLp;
    logic            C_EN;
    logic            CLR;
    logic            DONE;
    logic            host_we;
    logic [2:0]      host_row;
    logic [COLS-1:0] host_wdata;
    logic [COLS-1:0] host_rdata;
    logic [COLS-1:0] carry;
    logic            busy;
    logic            result_valid;
    logic            wl_err;
    logic            host_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cim_add_array #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RWLv1        (RWLv1),
        .RWLv2        (RWLv2),
        .WWLp         (WWLp),
        .C_EN         (C_EN),
        .CLR          (CLR),
        .DONE         (DONE),
        .host_we      (host_we),
        .host_row     (host_row),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .carry        (carry),
        .busy         (busy),
        .result_valid (result_valid),
        .wl_err       (wl_err),
        .host_err     (host_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RWLv1      = '0;
        RWLv2      = '0;
        WWLp       = '0;
        C_EN       = 1'b0;
        CLR        = 1'b0;
        DONE       = 1'b0;
        host_we    = 1'b0;
        host_wdata = '0;
    endtask

    task automatic host_write(input logic [2:0] row, input logic [7:0] data);
        host_we    = 1'b1;
        host_row   = row;
        host_wdata = data;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic read_row(input logic [2:0] row, output logic [7:0] data);
        host_row = row;
        tick();
        data = host_rdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        host_row = '0;
        rst_n = 1'b0;
        tick();
        tick();
        checks += 6;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", busy);
        end
        if (carry !== 8'h00) begin
            errors++; $display("FAIL reset_carry got %h want 00", carry);
        end
        if (host_rdata !== 8'h00) begin
            errors++; $display("FAIL reset_rdata got %h want 00", host_rdata);
        end
        if (result_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rv got %b want 0", result_valid);
        end
        if (wl_err !== 1'b0) begin
            errors++; $display("FAIL reset_wl_err got %b want 0", wl_err);
        end
        if (host_err !== 1'b0) begin
            errors++; $display("FAIL reset_host_err got %b want 0", host_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_no_carry();
        logic [7:0] d;
        host_write(3'd0, 8'hA5);
        host_write(3'd1, 8'h3C);
        host_write(3'd3, 8'hFF);
        checks++;
        if (host_err !== 1'b0) begin
            errors++; $display("FAIL load_host_err got %b want 0", host_err);
        end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        RWLv1 = 8'h01; RWLv2 = 8'h02; WWLp = 8'h04; C_EN = 1'b1;
        tick();
        idle_inputs();
        checks += 2;
        if (carry !== 8'h24) begin
            errors++; $display("FAIL add_carry got %h want 24", carry);
        end
        if (busy !== 1'b1) begin
            errors++; $display("FAIL add_busy got %b want 1", busy);
        end
        read_row(3'd2, d);
        checks++;
        if (d !== 8'h99) begin
            errors++; $display("FAIL add_row2 got %h want 99", d);
        end
    endtask

    task automatic test_ripple();
        logic [7:0] d;
        RWLv1 = 8'h08; RWLv2 = 8'h10; WWLp = 8'h20; C_EN = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (carry !== 8'h24) begin
            errors++; $display("FAIL ripple_carry got %h want 24", carry);
        end
        read_row(3'd5, d);
        checks++;
        if (d !== 8'hDB) begin
            errors++; $display("FAIL ripple_row5 got %h want DB", d);
        end
    endtask

    task automatic test_bad_wordline();
        logic [7:0] d;
        RWLv1 = 8'h03; RWLv2 = 8'h02; WWLp = 8'h80; C_EN = 1'b1;
        tick();
        idle_inputs();
        checks += 2;
        if (wl_err !== 1'b1) begin
            errors++; $display("FAIL bad_wl_err got %b want 1", wl_err);
        end
        if (carry !== 8'h24) begin
            errors++; $display("FAIL bad_carry got %h want 24", carry);
        end
        read_row(3'd7, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL bad_row7 got %h want 00", d);
        end
        read_row(3'd3, d);
        checks += 2;
        if (d !== 8'hFF) begin
            errors++; $display("FAIL bad_row3 got %h want FF", d);
        end
        if (wl_err !== 1'b1) begin
            errors++; $display("FAIL bad_sticky got %b want 1", wl_err);
        end
    endtask

    task automatic test_host_collision();
        logic [7:0] d;
        host_we = 1'b1; host_row = 3'd6; host_wdata = 8'h11;
        RWLv1 = 8'h01; RWLv2 = 8'h02; WWLp = 8'h40;
        tick();
        idle_inputs();
        checks++;
        if (host_err !== 1'b1) begin
            errors++; $display("FAIL coll_host_err got %b want 1", host_err);
        end
        tick();
        checks++;
        if (host_err !== 1'b0) begin
            errors++; $display("FAIL coll_err_pulse got %b want 0", host_err);
        end
        read_row(3'd6, d);
        checks++;
        if (d !== 8'hBD) begin
            errors++; $display("FAIL coll_row6 got %h want BD", d);
        end
        host_we = 1'b1; host_row = 3'd1; host_wdata = 8'hFF;
        tick();
        host_we = 1'b0;
        checks++;
        if (host_err !== 1'b1) begin
            errors++; $display("FAIL busy_host_err got %b want 1", host_err);
        end
        read_row(3'd1, d);
        checks += 2;
        if (d !== 8'h3C) begin
            errors++; $display("FAIL busy_row1 got %h want 3C", d);
        end
        if (host_err !== 1'b0) begin
            errors++; $display("FAIL busy_err_pulse got %b want 0", host_err);
        end
    endtask

    task automatic test_done();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL done_busy got %b want 0", busy);
        end
        if (result_valid !== 1'b1) begin
            errors++; $display("FAIL done_rv got %b want 1", result_valid);
        end
        tick();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++; $display("FAIL done_rv_pulse got %b want 0", result_valid);
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        checks += 2;
        if (result_valid !== 1'b1) begin
            errors++; $display("FAIL idle_done_rv got %b want 1", result_valid);
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_done_busy got %b want 0", busy);
        end
        tick();
    endtask

    task automatic test_read_during_write();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        host_row = 3'd0;
        RWLv1 = 8'h01; RWLv2 = 8'h02; WWLp = 8'h01;
        tick();
        idle_inputs();
        checks++;
        if (host_rdata !== 8'hA5) begin
            errors++; $display("FAIL rdw_old got %h want A5", host_rdata);
        end
        tick();
        checks += 2;
        if (host_rdata !== 8'h99) begin
            errors++; $display("FAIL rdw_new got %h want 99", host_rdata);
        end
        if (carry !== 8'h00) begin
            errors++; $display("FAIL rdw_carry got %h want 00", carry);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        RWLv1 = 8'h01; RWLv2 = 8'h02; WWLp = 8'h08; C_EN = 1'b1;
        host_row = 3'd0;
        rst_n = 1'b0;
        tick();
        checks += 4;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got %b want 0", busy);
        end
        if (carry !== 8'h00) begin
            errors++; $display("FAIL rst_carry got %h want 00", carry);
        end
        if (wl_err !== 1'b0) begin
            errors++; $display("FAIL rst_wl_err got %b want 0", wl_err);
        end
        if (host_rdata !== 8'h00) begin
            errors++; $display("FAIL rst_rdata got %h want 00", host_rdata);
        end
        idle_inputs();
        rst_n = 1'b1;
        read_row(3'd3, d);
        checks++;
        if (d !== 8'h00) begin
            errors++; $display("FAIL rst_row3 got %h want 00", d);
        end
        host_write(3'd2, 8'h55);
        checks++;
        if (host_err !== 1'b0) begin
            errors++; $display("FAIL rst_wr_err got %b want 0", host_err);
        end
        read_row(3'd2, d);
        checks++;
        if (d !== 8'h55) begin
            errors++; $display("FAIL rst_row2 got %h want 55", d);
        end
    endtask

    initial begin
        test_reset();
        test_add_no_carry();
        test_ripple();
        test_bad_wordline();
        test_host_collision();
        test_done();
        test_read_during_write();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
